// File: rtl/sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer
//
// Micro-sequencer for the 8-bit SAP-1.5 datapath. Walks the fetch T-states
// (T0, T1), then the execute T-states (T2..T4) selected by the opcode in
// IR[7:4]. It drives the bus-enable and load strobes for PC, MAR, IR, A, B,
// OUT, RAM and the flags register. HLT parks the machine in HALT until reset.
//
// Optional build feature: define CTRL_SINGLE_STEP_EN to make the state
// advance only on clock edges where step=1. The current strobes stay asserted
// while the state is held. Without the macro, step is ignored.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   opcode       in   IR[7:4], valid from T2 onward
//   flag_zero    in   registered Z flag (looked at in T2 only)
//   flag_carry   in   registered C flag (looked at in T2 only)
//   step         in   single-step advance (CTRL_SINGLE_STEP_EN builds only)
//   pc_oe, ram_oe, ir_oe, a_oe, alu_oe         out  bus drivers (one-hot or 0)
//   load_mar, load_ir, load_a, load_b,
//   load_out, load_ram, load_flags             out  register load strobes
//   pc_inc, pc_load                            out  PC controls
//   alu_sub      out  ALU subtract select (T4 of SUB only)
//   halt         out  machine halted
//   tstate       out  current T-state: 0-4, 7 = HALT (debug view of the FSM)
//
// Outputs are a Moore decode of (state, opcode, flags). All outputs are forced
// low while reset is held, so they drop without waiting for a clock edge.
// -----------------------------------------------------------------------------
module sap_control_sequencer #(
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_zero,
  input  logic                flag_carry,
  input  logic                step,
  output logic                pc_oe,
  output logic                ram_oe,
  output logic                ir_oe,
  output logic                a_oe,
  output logic                alu_oe,
  output logic                load_mar,
  output logic                load_ir,
  output logic                load_a,
  output logic                load_b,
  output logic                load_out,
  output logic                load_ram,
  output logic                load_flags,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                alu_sub,
  output logic                halt,
  output logic [2:0]          tstate
);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  state_t state, state_n;
  logic   advance;

`ifdef CTRL_SINGLE_STEP_EN
  assign advance = step;
`else
  // step has no function in this build.
  logic unused_step;
  assign unused_step = step;
  assign advance     = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= T0;
    else       state <= state_n;
  end

  // Next-state decode. The opcode is held in IR through T3, so T3 can
  // decide again between the 4-cycle and 5-cycle instructions.
  always_comb begin
    state_n = state;
    if (advance) begin
      case (state)
        T0: state_n = T1;
        T1: state_n = T2;
        T2: begin
          if (opcode == OP_LDA || opcode == OP_ADD ||
              opcode == OP_SUB || opcode == OP_STA) state_n = T3;
          else if (opcode == OP_HLT)                state_n = HALT;
          else                                      state_n = T0;
        end
        T3:      state_n = (opcode == OP_ADD || opcode == OP_SUB) ? T4 : T0;
        T4:      state_n = T0;
        HALT:    state_n = HALT;
        default: state_n = T0;
      endcase
    end
  end

  // Output decode. Opcodes 0x0 and 0x9-0xD fall through to "no strobes".
  always_comb begin
    pc_oe      = 1'b0;
    ram_oe     = 1'b0;
    ir_oe      = 1'b0;
    a_oe       = 1'b0;
    alu_oe     = 1'b0;
    load_mar   = 1'b0;
    load_ir    = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_out   = 1'b0;
    load_ram   = 1'b0;
    load_flags = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_sub    = 1'b0;
    halt       = 1'b0;
    if (!reset) begin
      case (state)
        T0: begin
          pc_oe    = 1'b1;
          load_mar = 1'b1;
        end
        T1: begin
          ram_oe  = 1'b1;
          load_ir = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_oe    = 1'b1;
              load_mar = 1'b1;
            end
            OP_LDI: begin
              ir_oe  = 1'b1;
              load_a = 1'b1;
            end
            OP_JMP: begin
              ir_oe   = 1'b1;
              pc_load = 1'b1;
            end
            // Conditional jumps read the flags here and nowhere else.
            OP_JC: begin
              ir_oe   = 1'b1;
              pc_load = flag_carry;
            end
            OP_JZ: begin
              ir_oe   = 1'b1;
              pc_load = flag_zero;
            end
            OP_OUT: begin
              a_oe     = 1'b1;
              load_out = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_oe = 1'b1;
              load_a = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_oe = 1'b1;
              load_b = 1'b1;
            end
            OP_STA: begin
              a_oe     = 1'b1;
              load_ram = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          alu_oe     = 1'b1;
          load_a     = 1'b1;
          load_flags = 1'b1;
          alu_sub    = (opcode == OP_SUB);
        end
        HALT:    halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign tstate = state;

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Micro-sequencer for the 8-bit SAP-1.5 datapath.
- Steps through fetch and execute T-states and drives the bus-enable and load strobes of the PC, MAR, IR, A, B, OUT, RAM and flags registers.
- Decodes the 4-bit opcode from the IR upper nibble. Instruction length varies from 3 to 5 cycles; HLT freezes the machine until reset.

Parameters:
OPCODE_W, 4, opcode width (IR upper nibble)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  OPCODE_W  IR[7:4], valid from T2 onward
flag_zero  input  1  registered Z flag
flag_carry  input  1  registered C flag
step  input  1  single-step advance pulse (used only under CTRL_SINGLE_STEP_EN)
pc_oe  output  1  PC drives bus
ram_oe  output  1  RAM[MAR] drives bus
ir_oe  output  1  IR[3:0] operand drives bus (zero-extended)
a_oe  output  1  A drives bus
alu_oe  output  1  ALU result drives bus
load_mar / load_ir / load_a / load_b / load_out / load_ram / load_flags  output  1 each  register load strobes
pc_inc  output  1  PC increment
pc_load  output  1  PC loads from bus
alu_sub  output  1  ALU subtract select
halt  output  1  machine halted
tstate  output  3  current T-state (0-4, 7 = HALT) for debug/LEDs

Behaviour:
- Clock, reset and encoding
  - One clock; reset is asynchronous and active-high.
  - reset forces state T0. Every strobe, enable and halt is 0 while reset is held; tstate = 0.
  - States are T0..T4 and HALT, encoded 0-4 and 7.
  - Outputs are a Moore decode of (state, opcode, flags). At most one *_oe may be high in any cycle.
- Fetch (all instructions)
  - T0: pc_oe, load_mar.
  - T1: ram_oe, load_ir, pc_inc.
  - T2: execute begins with the freshly latched opcode.
- Execute. "->T0" means the next edge returns to T0.
  - 0x0 NOP: T2 no strobes ->T0.
  - 0x1 LDA: T2 ir_oe, load_mar; T3 ram_oe, load_a ->T0.
  - 0x2 ADD: T2 ir_oe, load_mar; T3 ram_oe, load_b; T4 alu_oe, load_a, load_flags, alu_sub=0 ->T0.
  - 0x3 SUB: as ADD, with alu_sub=1 in T4 only.
  - 0x4 STA: T2 ir_oe, load_mar; T3 a_oe, load_ram ->T0.
  - 0x5 LDI: T2 ir_oe, load_a ->T0.
  - 0x6 JMP: T2 ir_oe, pc_load ->T0.
  - 0x7 JC: T2 ir_oe, and pc_load only if flag_carry=1 ->T0.
  - 0x8 JZ: T2 ir_oe, and pc_load only if flag_zero=1 ->T0.
  - 0xE OUT: T2 a_oe, load_out ->T0.
  - 0xF HLT: T2 no strobes -> HALT.
  - 0x9-0xD undefined: treated as NOP, 3 cycles.
- Cycle counts: NOP/LDI/JMP/JC/JZ/OUT = 3; LDA/STA = 4; ADD/SUB = 5.
- Flag sampling: flags are sampled combinationally in T2 only. A flag change in any other state has no effect.
- HALT: halt=1 and all other outputs 0. The state is held indefinitely; only reset exits it.
- Reset mid-instruction: the sequencer aborts immediately (asynchronously), and the next fetch starts at T0 on the first edge after reset deasserts. Partially executed instructions are not resumed.
- alu_sub is 0 in every state other than T4 of SUB.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - The state advances only on clock edges where step=1. With step=0 the state holds and the current strobes stay asserted.
  - A 1-cycle step pulse completes exactly one T-state.
  - HALT and reset behave as normal.
- Undefined: step is ignored and the state advances every clock.

Test Plan:
1. Reset held for 3 cycles, then released -> all strobes 0 during reset; cycle 1 shows tstate=0 with pc_oe=1, load_mar=1; cycle 2 shows tstate=1 with ram_oe=1, load_ir=1, pc_inc=1.
2. opcode=0x2 (ADD), then opcode=0x3 (SUB) -> T2..T4 strobes exactly as listed; alu_sub=1 only in T4 of SUB; 5 cycles per instruction; tstate returns to 0.
3. JC with flag_carry=0, then with flag_carry=1; JZ with flag_zero=1; flags toggled in T0/T1 -> pc_load=1 only in T2 of JC(C=1) and JZ(Z=1); 3 cycles each; no effect from toggling outside T2.
4. opcode=0xB (undefined) -> 3-cycle NOP with no strobes in T2. opcode=0xF -> halt=1 and tstate=7 from the cycle after T2, held for 20 cycles with all strobes 0.
5. Assert reset in T3 of LDA, and separately while in HALT -> outputs drop to 0 without waiting for a clock edge; halt clears; fetch restarts at T0.
6. With CTRL_SINGLE_STEP_EN defined: step low for 5 cycles, then one pulse per 4 cycles during LDA -> state changes only on step edges; load_a stays asserted throughout the held T3.
